// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg -- one pipeline stage register with a valid/ready handshake
// on both sides, flush support and a saturating back-pressure counter.
//
// Build option: define PIPE_STAGE_SKID_EN to get a two-entry skid buffer.
// With the skid buffer, in_ready depends only on the state register.
// Without it (the default), the stage holds one entry and in_ready is
// combinational from out_ready.
//
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high. A producer holds valid and its payload until that edge. The
// stage never withdraws out_valid and never changes out_ctrl/out_data while
// out_valid=1 and out_ready=0.
//
// Ports:
//   clk        sole clock, rising edge
//   rst        synchronous active-high reset
//   in_valid   upstream offers an entry
//   in_ready   stage accepts an entry this cycle
//   in_ctrl    upstream control bits (CTRL_W)
//   in_data    upstream payload (DATA_W)
//   flush      squash every held entry and any entry accepted this cycle
//   out_valid  out_ctrl/out_data carry a live entry
//   out_ready  downstream consumes the entry this cycle
//   out_ctrl   registered control bits, forced to zero (NOP) when empty
//   out_data   registered payload, keeps its last value when empty
//   stall_cnt  saturating count of cycles with out_valid && !out_ready
//   dbg_state  current FSM state (0 EMPTY, 1 FULL, 2 SKID)
module pipe_stage_reg #(
  parameter int DATA_W = 101,
  parameter int CTRL_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_FULL  = 2'd1,
    S_SKID  = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [CTRL_W-1:0] ctrl_q;
  logic [DATA_W-1:0] data_q;
  logic [CNT_W-1:0]  stall_q;

  logic accept;
  logic load_out;   // output slot takes the incoming entry

`ifdef PIPE_STAGE_SKID_EN
  logic [CTRL_W-1:0] skid_ctrl_q;
  logic [DATA_W-1:0] skid_data_q;
  logic load_skid;  // incoming entry parks in the skid slot
  logic move_skid;  // skid entry advances into the output slot
`endif

  assign out_valid = (state != S_EMPTY);

`ifdef PIPE_STAGE_SKID_EN
  // Decoded from the state register only, so there is no path from out_ready.
  assign in_ready = (state != S_SKID);
`else
  assign in_ready = !out_valid || out_ready;
`endif

  assign accept = in_valid && in_ready;

  always_comb begin
    state_nxt = state;
    load_out  = 1'b0;
`ifdef PIPE_STAGE_SKID_EN
    load_skid = 1'b0;
    move_skid = 1'b0;
`endif
    if (flush) begin
      state_nxt = S_EMPTY;
    end else begin
      case (state)
        S_EMPTY: begin
          if (accept) begin
            state_nxt = S_FULL;
            load_out  = 1'b1;
          end
        end
        S_FULL: begin
`ifdef PIPE_STAGE_SKID_EN
          if (accept && out_ready) begin
            load_out = 1'b1;
          end else if (accept) begin
            state_nxt = S_SKID;
            load_skid = 1'b1;
          end else if (out_ready) begin
            state_nxt = S_EMPTY;
          end
`else
          // In FULL an accept implies out_ready, so the slot is refilled.
          if (accept) begin
            load_out = 1'b1;
          end else if (out_ready) begin
            state_nxt = S_EMPTY;
          end
`endif
        end
`ifdef PIPE_STAGE_SKID_EN
        S_SKID: begin
          if (out_ready) begin
            state_nxt = S_FULL;
            move_skid = 1'b1;
          end
        end
`endif
        default: state_nxt = S_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_EMPTY;
      ctrl_q <= '0;
      data_q <= '0;
`ifdef PIPE_STAGE_SKID_EN
      skid_ctrl_q <= '0;
      skid_data_q <= '0;
`endif
    end else begin
      state <= state_nxt;
      if (load_out) begin
        ctrl_q <= in_ctrl;
        data_q <= in_data;
      end
`ifdef PIPE_STAGE_SKID_EN
      if (move_skid) begin
        ctrl_q <= skid_ctrl_q;
        data_q <= skid_data_q;
      end
      if (load_skid) begin
        skid_ctrl_q <= in_ctrl;
        skid_data_q <= in_data;
      end
`endif
    end
  end

  // Counts every back-pressured cycle, including one that also flushes;
  // only reset clears it.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= '0;
    end else if (out_valid && !out_ready && (stall_q != {CNT_W{1'b1}})) begin
      stall_q <= stall_q + CNT_W'(1);
    end
  end

  // Empty stage presents a NOP control word so downstream never writes.
  assign out_ctrl  = out_valid ? ctrl_q : '0;
  assign out_data  = data_q;
  assign stall_cnt = stall_q;
  assign dbg_state = state;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg -- directed and random checks of pipe_stage_reg against
// a queue model of the entries held in the stage.
module tb_pipe_stage_reg;

  localparam int DATA_W = 101;
  localparam int CTRL_W = 8;
  localparam int CNT_W  = 12;
  localparam int EW     = CTRL_W + DATA_W;
  localparam int MAXC   = (1 << CNT_W) - 1;
`ifdef PIPE_STAGE_SKID_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif

  logic              clk;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [CTRL_W-1:0] in_ctrl;
  logic [DATA_W-1:0] in_data;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic [CTRL_W-1:0] out_ctrl;
  logic [DATA_W-1:0] out_data;
  logic [CNT_W-1:0]  stall_cnt;
  logic [1:0]        dbg_state;

  pipe_stage_reg #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl), .out_data(out_data),
    .stall_cnt(stall_cnt), .dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard / model ----------------
  logic [EW-1:0]     exp_q[$];    // entries held by the stage, oldest first
  int                m_cnt;       // expected stall count
  logic [DATA_W-1:0] m_last;      // payload last presented at the output
  int                n_checks;
  int                n_fail;
  int                n_out;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic model_ready(input logic ordy);
    if (SKID) return exp_q.size() < 2;
    return (exp_q.size() == 0) || ordy;
  endfunction

  // One clock cycle: drive inputs, compare outputs against the model at the
  // falling edge, then advance the model across the rising edge.
  task automatic cycle(input logic iv, input logic [CTRL_W-1:0] ic,
                       input logic [DATA_W-1:0] id, input logic fl,
                       input logic ordy, input logic r);
    logic m_rdy;
    logic acc;
    logic [EW-1:0] head;
    in_valid  = iv;
    in_ctrl   = ic;
    in_data   = id;
    flush     = fl;
    out_ready = ordy;
    rst       = r;
    @(negedge clk);
    m_rdy = model_ready(ordy);
    head  = (exp_q.size() > 0) ? exp_q[0] : '0;
    check("in_ready", in_ready, m_rdy);
    check("out_valid", out_valid, exp_q.size() > 0);
    check("out_ctrl", out_ctrl, (exp_q.size() > 0) ? head[EW-1:DATA_W] : '0);
    check("out_data", out_data, (exp_q.size() > 0) ? head[DATA_W-1:0] : m_last);
    check("stall_cnt", stall_cnt, m_cnt);
    acc = iv && m_rdy;
    @(posedge clk);
    #1;
    if (r) begin
      exp_q.delete();
      m_cnt  = 0;
      m_last = '0;
    end else begin
      if (exp_q.size() > 0 && !ordy && m_cnt < MAXC) m_cnt++;
      if (fl) begin
        exp_q.delete();
      end else begin
        if (exp_q.size() > 0 && ordy) begin
          void'(exp_q.pop_front());
          n_out++;
        end
        if (acc) exp_q.push_back({ic, id});
      end
      if (exp_q.size() > 0) begin
        head   = exp_q[0];
        m_last = head[DATA_W-1:0];
      end
    end
  endtask

  function automatic logic [DATA_W-1:0] rand_data();
    logic [127:0] t;
    t = {$urandom(), $urandom(), $urandom(), $urandom()};
    return t[DATA_W-1:0];
  endfunction

  task automatic idle(input int n, input logic ordy);
    for (int i = 0; i < n; i++) cycle(1'b0, '0, '0, 1'b0, ordy, 1'b0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    n_checks = 0; n_fail = 0; n_out = 0;
    m_cnt = 0; m_last = '0;
    in_valid = 0; in_ctrl = '0; in_data = '0; flush = 0; out_ready = 0;
    rst = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;

    // Reset state
    check("rst_out_valid", out_valid, 0);
    check("rst_out_ctrl", out_ctrl, 0);
    check("rst_out_data", out_data, 0);
    check("rst_stall", stall_cnt, 0);
    check("rst_in_ready", in_ready, 1);

    // Back-to-back stream of 8 entries with the consumer always ready
    for (int k = 0; k < 8; k++)
      cycle(1'b1, CTRL_W'(k + 1), DATA_W'(100 + k), 1'b0, 1'b1, 1'b0);
    check("stream_last_data", out_data, 107);
    idle(3, 1'b1);
    check("stream_count", n_out, 8);
    check("stream_stall", stall_cnt, 0);

    // Hold one entry under back-pressure for 5 cycles
    cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, 8'h8F, DATA_W'(55), 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++)
      cycle(1'b1, 8'h21, DATA_W'(66), 1'b0, 1'b0, 1'b0);
    check("hold_ctrl", out_ctrl, 8'h8F);
    check("hold_data", out_data, 55);
    check("hold_stall", stall_cnt, 5);
    check("hold_in_ready", in_ready, 0);
`ifdef PIPE_STAGE_SKID_EN
    check("hold_skid_state", dbg_state, 2);
`endif
    idle(3, 1'b1);

    // Flush with an entry held and a new one offered
    cycle(1'b1, 8'h33, DATA_W'(77), 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 8'hEE, DATA_W'(999), 1'b1, 1'b0, 1'b0);
    check("flush_out_valid", out_valid, 0);
    check("flush_out_ctrl", out_ctrl, 0);
    idle(3, 1'b1);

    // Stall counter saturation, then flush must not clear it
    cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, 8'h44, DATA_W'(88), 1'b0, 1'b0, 1'b0);
    idle(MAXC + 100, 1'b0);
    check("sat_stall", stall_cnt, MAXC);
    cycle(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
    idle(2, 1'b1);
    check("sat_after_flush", stall_cnt, MAXC);

    // Reset with the stage as full as it gets
    cycle(1'b1, 8'h51, DATA_W'(1), 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 8'h52, DATA_W'(2), 1'b0, 1'b0, 1'b0);
    cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_stall", stall_cnt, 0);
    check("midrst_in_ready", in_ready, 1);
    n_out = 0;
    idle(3, 1'b1);
    check("midrst_no_emit", n_out, 0);

    // Random traffic with occasional flush
    for (int k = 0; k < 10000; k++)
      cycle(1'($urandom_range(0, 1)), CTRL_W'($urandom_range(0, 255)), rand_data(),
            ($urandom_range(0, 99) == 0), 1'($urandom_range(0, 1)), 1'b0);
    idle(4, 1'b1);
    check("rand_drained", out_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 SHALL provide parameter DATA_W, default 101, meaning width of the datapath payload (dest reg 5 + regA 32 + regB 32 + extended imm 32).
REQ-002 SHALL provide parameter CTRL_W, default 8, meaning width of the control payload (wreg, m2reg, wmem, aluimm, aluc[3:0]).
REQ-003 SHALL provide parameter CNT_W, default 16, meaning width of the stall counter.
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-006 SHALL have port in_valid  input  1  upstream stage offers an entry.
REQ-007 SHALL have port in_ready  output  1  this stage accepts an entry this cycle.
REQ-008 SHALL have port in_ctrl  input  CTRL_W  upstream control bits.
REQ-009 SHALL have port in_data  input  DATA_W  upstream payload.
REQ-010 SHALL have port flush  input  1  squash all held entries (branch/exception kill).
REQ-011 SHALL have port out_valid  output  1  out_ctrl/out_data hold a live entry.
REQ-012 SHALL have port out_ready  input  1  downstream stage consumes the entry this cycle.
REQ-013 SHALL have port out_ctrl  output  CTRL_W  registered control bits.
REQ-014 SHALL have port out_data  output  DATA_W  registered payload.
REQ-015 SHALL have port stall_cnt  output  CNT_W  count of back-pressured cycles.

Function
REQ-016 SHALL accept an entry when in_valid && in_ready at a rising edge; output it on the next edge (1-cycle latency, 1 entry/cycle sustained when out_ready=1).
REQ-017 SHALL present an entry until out_valid && out_ready; out_ctrl/out_data SHALL be stable while out_valid=1 and out_ready=0.
REQ-018 SHALL drive out_ctrl to all-zero whenever out_valid=0 (bubble = NOP, no register/memory write); out_data retains its last value.
REQ-019 SHALL preserve entry order; no entry duplicated or dropped except by flush/rst.
REQ-020 On flush=1 SHALL discard all held entries and any entry accepted that cycle; next cycle out_valid=0, state EMPTY.
REQ-021 flush and rst together: rst behaviour applies.
REQ-022 stall_cnt SHALL increment by 1 on each cycle with out_valid=1 and out_ready=0, saturate at 2^CNT_W-1, and clear only on rst (not on flush).
REQ-023 Simultaneous accept and consume in the same cycle SHALL leave occupancy unchanged and load the new entry.

Reset
REQ-024 On rst=1 at a rising edge: out_valid=0, out_ctrl=0, out_data=0, stall_cnt=0, state EMPTY; in_ready=1 on the following cycle.
REQ-025 rst mid-transfer SHALL discard both held entries (skid included) with no output handshake.

Configuration
REQ-026 Macro PIPE_STAGE_SKID_EN undefined: single-entry stage, states EMPTY/FULL; in_ready = !out_valid || out_ready (combinational from out_ready).
REQ-027 Macro PIPE_STAGE_SKID_EN defined: two-entry skid buffer, states EMPTY/FULL/SKID; in_ready registered, equal to (state != SKID).
REQ-028 With SKID_EN: EMPTY->FULL on accept; FULL->SKID on accept && !out_ready (incoming entry to skid slot); SKID->FULL on out_ready (skid entry moves to output, no accept); FULL->EMPTY on out_ready && !accept; FULL stays on accept && out_ready.
REQ-029 Both configurations SHALL have identical out_* behaviour for any stimulus that never fills the skid slot.

Verification
REQ-030 Stream 8 entries, in_valid=1, out_ready=1: outputs appear 1 cycle later in order, stall_cnt=0.
REQ-031 Load in_ctrl=0x8F, hold out_ready=0 for 5 cycles: out_ctrl stays 0x8F, stall_cnt=5; SKID_EN build holds a second entry and deasserts in_ready.
REQ-032 flush=1 with entry held and in_valid=1: next cycle out_valid=0, out_ctrl=0x00; incoming entry never appears.
REQ-033 Hold out_ready=0 with out_valid=1 for 70000 cycles (CNT_W=16): stall_cnt saturates at 0xFFFF; subsequent flush leaves 0xFFFF.
REQ-034 Assert rst while SKID state (two entries): next cycle out_valid=0, stall_cnt=0, in_ready=1, neither entry emitted.
REQ-035 Random in_valid/out_ready at 50% each, 10000 cycles, both macro settings: scoreboard confirms in-order, lossless delivery.
